count_monitor: RTL and testbench
================================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2, the number of consecutive identical synchronised samples (range 1-15) required to accept a counter value.
REQ-002 SHALL have parameter EXT_W, default 8, the width of the wrap-extension field above the 8-bit count.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port EN  input  1  monitor enable.
REQ-006 SHALL have port counter  input  8  ripple-counter value, asynchronous to CLK.
REQ-007 SHALL have port thresh  input  8  compare value, quasi-static.
REQ-008 SHALL have port value  output  8+EXT_W  extended count {ext, last}.
REQ-009 SHALL have port value_valid  output  1  value holds an untransferred update.
REQ-010 SHALL have port value_ready  input  1  consumer accepts value this cycle.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on detected 255->0 rollover.
REQ-012 SHALL have port match  output  1  one-cycle pulse on accepted value equal to thresh.
REQ-013 SHALL have port overrun  output  1  sticky: an update replaced an untransferred one.

Function
REQ-014 SHALL pass each counter bit through a two-flop synchroniser before any use.
REQ-015 SHALL accept a sample only after the synchronised value is identical for STABLE_CYCLES consecutive CLK cycles, which masks ripple glitches.
REQ-016 SHALL produce a value_valid rise exactly 2+STABLE_CYCLES rising edges after a setup-clean counter change.
REQ-017 SHALL implement states IDLE, ACQUIRE and TRACK.
REQ-018 SHALL transition IDLE->ACQUIRE on EN=1, ACQUIRE->TRACK on the first accepted sample, and any state->IDLE on EN=0 at the next edge.
REQ-019 SHALL, in ACQUIRE, load the accepted sample into last without a wrap, match or valid update.
REQ-020 SHALL, in TRACK, update last when an accepted sample differs from last; an accepted sample equal to last SHALL cause no update.
REQ-021 SHALL, on an update where new < last, increment ext modulo 2^EXT_W and pulse wrap for one cycle.
REQ-022 SHALL, on an update where the new value equals thresh, pulse match for one cycle.
REQ-023 SHALL set value_valid on each update, and SHALL clear it only on an edge where value_valid=1 and value_ready=1 with no simultaneous update.
REQ-024 SHALL keep value_valid=1 and present the new value when a transfer and an update coincide; overrun SHALL NOT be set in that case.
REQ-025 SHALL, on an update while value_valid=1 and value_ready=0, overwrite value and set overrun; overrun SHALL be cleared only by reset or entry to IDLE.
REQ-026 SHALL, on entry to IDLE, clear ext, value_valid, wrap, match and overrun, and SHALL retain last.

Reset
REQ-027 SHALL, on RST=1, immediately force state=IDLE, synchroniser and stability counter to 0, last=0, ext=0, value=0, value_valid=0, wrap=0, match=0 and overrun=0.
REQ-028 SHALL, after RST deasserts mid-operation, restart through ACQUIRE with no wrap from the pre-reset value.

Configuration
REQ-029 SHALL, with macro COUNT_MONITOR_MATCH_EN defined, include the thresh compare and drive match per REQ-022.
REQ-030 SHALL, without COUNT_MONITOR_MATCH_EN, tie match to 0, ignore thresh and contain no compare logic.

Structure
REQ-031 SHALL take the state enum (IDLE, ACQUIRE, TRACK) and the constant COUNT_W=8 from the shared package count_monitor_pkg.
REQ-032 SHALL implement the synchroniser plus stability filter as the sub-module count_sync_filter, with output the accepted value plus a one-cycle accept strobe.

Verification
REQ-033 SHALL cover: reset, EN=1, counter held at 0x05 -> state reaches TRACK, last=0x05, value_valid=0, no pulses.
REQ-034 SHALL cover: in TRACK, counter 0x05->0x06 with value_ready=1, STABLE_CYCLES=2 -> value_valid high 4 edges later, value=0x0006, deasserts the next cycle.
REQ-035 SHALL cover: counter 0xFF->0x00 -> wrap pulses exactly once, value=0x0100.
REQ-036 SHALL cover: counter glitch 0x07->0x04->0x08 with the 0x04 held one cycle -> 0x04 never accepted, no wrap, value=0x0008.
REQ-037 SHALL cover: thresh=0x10, counter steps to 0x10 -> match pulses once with COUNT_MONITOR_MATCH_EN defined, match stays 0 without it.
REQ-038 SHALL cover: value_ready=0 through two updates 0x20, 0x21 -> value=0x0021 and overrun=1; then EN=0 -> overrun=0 and value_valid=0.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// Shared types and constants for the ripple-counter monitor.
package count_monitor_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    // A smaller accepted value than the last one means the counter rolled over.
    function automatic logic is_rollover(input logic [COUNT_W-1:0] nv,
                                         input logic [COUNT_W-1:0] ov);
        return nv < ov;
    endfunction

endpackage

// File: rtl/count_sync_filter.sv
// Two-flop synchroniser plus stability filter for an asynchronous ripple counter.
module count_sync_filter
    import count_monitor_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               rearm,
    input  logic [COUNT_W-1:0] counter,
    output logic [COUNT_W-1:0] sample,
    output logic               accept
);

    localparam int HW = 5;
    localparam logic [HW-1:0] HELD_ACC = HW'(STABLE_CYCLES);
    localparam logic [HW-1:0] HELD_MAX = HW'(STABLE_CYCLES + 1);

    logic [COUNT_W-1:0] s1, s2;
    logic [HW-1:0]      held;

    // held counts cycles s2 has shown its current value; saturating one past
    // the threshold keeps the accept strobe to a single cycle per value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1   <= '0;
            s2   <= '0;
            held <= '0;
        end else begin
            s1 <= counter;
            s2 <= s1;
            if (rearm)
                held <= '0;
            else if (s1 != s2)
                held <= HW'(1);
            else if (held != HELD_MAX)
                held <= held + HW'(1);
        end
    end

    assign sample = s2;
    assign accept = (held == HELD_ACC);

endmodule

// File: rtl/count_monitor.sv
// Ripple-counter monitor: filtered sampling, wrap extension and valid/ready output.
// Optional thresh compare driving match is built only with COUNT_MONITOR_MATCH_EN.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int EXT_W         = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic [COUNT_W-1:0]       counter,
    input  logic [COUNT_W-1:0]       thresh,
    output logic [COUNT_W+EXT_W-1:0] value,
    output logic                     value_valid,
    input  logic                     value_ready,
    output logic                     wrap,
    output logic                     match,
    output logic                     overrun
);

    state_t             state;
    logic [COUNT_W-1:0] last;
    logic [EXT_W-1:0]   ext;
    logic [EXT_W-1:0]   ext_next;
    logic [COUNT_W-1:0] sample;
    logic               accept;
    logic               update;
    logic               rolled;
    logic               match_hit;

    count_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .CLK    (CLK),
        .RST    (RST),
        .rearm  (state == IDLE),
        .counter(counter),
        .sample (sample),
        .accept (accept)
    );

    assign update   = (state == TRACK) && accept && (sample != last);
    assign rolled   = is_rollover(sample, last);
    assign ext_next = ext + EXT_W'(rolled);

`ifdef COUNT_MONITOR_MATCH_EN
    assign match_hit = (sample == thresh);
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign match_hit     = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            last        <= '0;
            ext         <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            wrap        <= 1'b0;
            match       <= 1'b0;
            overrun     <= 1'b0;
        end else if (!EN) begin
            // last survives so a later restart can report it; everything else clears
            state       <= IDLE;
            ext         <= '0;
            value_valid <= 1'b0;
            wrap        <= 1'b0;
            match       <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            wrap  <= update && rolled;
            match <= update && match_hit;

            if (update) begin
                last        <= sample;
                ext         <= ext_next;
                value       <= {ext_next, sample};
                value_valid <= 1'b1;
                if (value_valid && !value_ready)
                    overrun <= 1'b1;
            end else if (value_valid && value_ready) begin
                value_valid <= 1'b0;
            end

            unique case (state)
                IDLE:    state <= ACQUIRE;
                ACQUIRE: if (accept) begin
                    last  <= sample;
                    state <= TRACK;
                end
                TRACK:   state <= TRACK;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed and randomised checks of count_monitor against a transaction-level model.
module tb_count_monitor;
    import count_monitor_pkg::*;

    localparam int S     = 2;
    localparam int EXT_W = 8;
`ifdef COUNT_MONITOR_MATCH_EN
    localparam bit MATCH_ON = 1'b1;
`else
    localparam bit MATCH_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST, EN, value_ready;
    logic [7:0]  counter, thresh;
    logic [15:0] value;
    logic        value_valid, wrap, match, overrun;

    int tests = 0, fails = 0;
    int wrap_cnt = 0, match_cnt = 0;

    count_monitor #(.STABLE_CYCLES(S), .EXT_W(EXT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .counter    (counter),
        .thresh     (thresh),
        .value      (value),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .wrap       (wrap),
        .match      (match),
        .overrun    (overrun)
    );

    always #5 CLK = ~CLK;

    // pulses last one cycle, so one sample per negedge counts each exactly once
    always @(negedge CLK) begin
        if (wrap)  wrap_cnt++;
        if (match) match_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic settle(input logic [7:0] v);
        counter = v;
        tick(S + 6);
    endtask

    initial begin
        int n, w0, m0, exp_w, exp_m;
        logic [7:0]  m_last, m_ext, v;
        logic [15:0] m_value;
        logic        m_valid, m_ovr, r;

        RST = 1'b1; EN = 1'b0; counter = 8'h00; thresh = 8'h10; value_ready = 1'b0;
        tick(2);
        check("rst_state", dut.state, IDLE);
        check("rst_value", value, 16'h0000);
        check("rst_valid", value_valid, 1'b0);
        check("rst_pulses", {wrap, match, overrun}, 3'b000);
        check("rst_last", dut.last, 8'h00);

        // acquire from a held counter
        RST = 1'b0; EN = 1'b1; counter = 8'h05;
        tick(S + 8);
        check("acq_state", dut.state, TRACK);
        check("acq_last", dut.last, 8'h05);
        check("acq_valid", value_valid, 1'b0);
        check("acq_wraps", wrap_cnt, 0);
        check("acq_matches", match_cnt, 0);

        // latency from a setup-clean change to value_valid
        value_ready = 1'b1; counter = 8'h06; n = 0;
        while (n < 20) begin
            @(posedge CLK); #1; n++;
            if (value_valid) break;
        end
        check("latency", n, 2 + S);
        @(negedge CLK);
        check("lat_value", value, 16'h0006);
        tick(1);
        check("lat_drop", value_valid, 1'b0);

        // rollover
        w0 = wrap_cnt;
        settle(8'hFF);
        check("ff_value", value, 16'h00FF);
        check("ff_nowrap", wrap_cnt - w0, 0);
        settle(8'h00);
        check("wrap_once", wrap_cnt - w0, 1);
        check("wrap_value", value, 16'h0100);

        // fresh run, then a one-cycle glitch that must be filtered out
        EN = 1'b0; tick(2);
        check("idle_ext", dut.ext, 8'h00);
        EN = 1'b1; tick(S + 8);
        check("reacq_state", dut.state, TRACK);
        settle(8'h07);
        check("pre_glitch", value, 16'h0007);
        w0 = wrap_cnt;
        counter = 8'h04; tick(1);
        settle(8'h08);
        check("glitch_nowrap", wrap_cnt - w0, 0);
        check("glitch_value", value, 16'h0008);

        // threshold compare
        m0 = match_cnt;
        settle(8'h10);
        check("match_cnt", match_cnt - m0, MATCH_ON ? 1 : 0);
        check("match_value", value, 16'h0010);

        // overrun, then disable clears it
        value_ready = 1'b0;
        settle(8'h20);
        check("ovr_first", overrun, 1'b0);
        settle(8'h21);
        check("ovr_value", value, 16'h0021);
        check("ovr_set", overrun, 1'b1);
        check("ovr_valid", value_valid, 1'b1);
        EN = 1'b0; tick(1);
        check("dis_ovr", overrun, 1'b0);
        check("dis_valid", value_valid, 1'b0);

        // reset mid-operation restarts without a spurious wrap
        EN = 1'b1; value_ready = 1'b1;
        settle(8'h80);
        check("pre_rst_last", dut.last, 8'h80);
        w0 = wrap_cnt;
        RST = 1'b1; counter = 8'h10; tick(1);
        check("midrst_value", value, 16'h0000);
        RST = 1'b0; tick(S + 8);
        check("post_rst_state", dut.state, TRACK);
        check("post_rst_last", dut.last, 8'h10);
        check("post_rst_nowrap", wrap_cnt - w0, 0);
        check("post_rst_valid", value_valid, 1'b0);

        // randomised phase: model works on accepted values only
        thresh = 8'($urandom);
        m_last = 8'h10; m_ext = 8'h00; m_value = 16'h0000; m_valid = 1'b0; m_ovr = 1'b0;
        w0 = wrap_cnt; m0 = match_cnt; exp_w = 0; exp_m = 0;
        for (int step = 0; step < 60; step++) begin
            r = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) == 0) ? thresh : 8'($urandom);
            value_ready = r;
            if ($urandom_range(0, 2) == 0) begin
                counter = 8'($urandom);
                tick(1);
            end
            settle(v);
            if (r) m_valid = 1'b0;
            if (v != m_last) begin
                if (m_valid) m_ovr = 1'b1;
                if (v < m_last) begin
                    m_ext = m_ext + 8'd1;
                    exp_w++;
                end
                if (MATCH_ON && v == thresh) exp_m++;
                m_last  = v;
                m_value = {m_ext, v};
                m_valid = !r;
            end
            check("rnd_value", value, m_value);
            check("rnd_valid", value_valid, m_valid);
            check("rnd_overrun", overrun, m_ovr);
            check("rnd_wraps", wrap_cnt - w0, exp_w);
            check("rnd_matches", match_cnt - m0, exp_m);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
